// File: rtl/fetch_if.sv
// Signal bundle between the LEGv8 IF stage and its surroundings: redirect
// controls from later stages, the instruction ROM port and the IF/ID register.
interface fetch_if #(
    parameter int N       = 64,
    parameter int IMEM_AW = 7
);
  logic               stall_i;
  logic               branch_taken_i;
  logic [N-1:0]       branch_target_i;
  logic               exc_i;
  logic               eret_i;
  logic [N-1:0]       elr_i;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_q_i;
  logic [N-1:0]       pc_o;
  logic               ifid_valid_o;
  logic [N-1:0]       ifid_pc_o;
  logic [31:0]        ifid_instr_o;
  logic               ifid_fault_o;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i, exc_i, eret_i, elr_i, imem_q_i,
    output imem_addr_o, pc_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, ifid_fault_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, exc_i, eret_i, elr_i, imem_q_i,
    input  imem_addr_o, pc_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, ifid_fault_o
  );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, next-PC selection, combinational
// ROM addressing and the IF/ID pipeline register with fetch-fault tagging.
module fetch_stage #(
    parameter int           N          = 64,
    parameter int           IMEM_AW    = 7,
    parameter logic [N-1:0] EXC_VECTOR = 64'h00000000000000D8
) (
    input logic    clk,
    input logic    reset,
    fetch_if.master bus
);

  logic [N-1:0] pc_reg;
  logic [N-1:0] pc_next;
  logic         ifid_valid_reg;
  logic [N-1:0] ifid_pc_reg;
  logic [31:0]  ifid_instr_reg;
  logic         ifid_fault_reg;
  logic         fault;
  logic         redirect;

  // Misaligned, or above the ROM's reach: the word fetched is not trustworthy.
  assign fault    = (pc_reg[1:0] != 2'b00) || (pc_reg[N-1:IMEM_AW+2] != '0);
  assign redirect = bus.exc_i || bus.eret_i || bus.branch_taken_i;

  always_comb begin
    pc_next = pc_reg + N'(4);
    if (bus.exc_i)               pc_next = EXC_VECTOR;
    else if (bus.eret_i)         pc_next = bus.elr_i;
    else if (bus.branch_taken_i) pc_next = bus.branch_target_i;
    else if (bus.stall_i)        pc_next = pc_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg         <= '0;
      ifid_valid_reg <= 1'b0;
      ifid_pc_reg    <= '0;
      ifid_instr_reg <= 32'h0;
      ifid_fault_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      // A redirect kills the wrong-path instruction even while stalled.
      if (redirect) begin
        ifid_valid_reg <= 1'b0;
        ifid_pc_reg    <= '0;
        ifid_instr_reg <= 32'h0;
        ifid_fault_reg <= 1'b0;
      end else if (!bus.stall_i) begin
        ifid_valid_reg <= 1'b1;
        ifid_pc_reg    <= pc_reg;
        ifid_instr_reg <= fault ? 32'h0 : bus.imem_q_i;
        ifid_fault_reg <= fault;
      end
    end
  end

  assign bus.imem_addr_o  = pc_reg[IMEM_AW+1:2];
  assign bus.pc_o         = pc_reg;
  assign bus.ifid_valid_o = ifid_valid_reg;
  assign bus.ifid_pc_o    = ifid_pc_reg;
  assign bus.ifid_instr_o = ifid_instr_reg;
  assign bus.ifid_fault_o = ifid_fault_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios from the fetch rules plus a
// randomized run checked against a cycle-level behavioural model.
module tb_fetch_stage;
  localparam int N  = 64;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if #(.N(N), .IMEM_AW(AW)) bus ();

  fetch_stage #(.N(N), .IMEM_AW(AW), .EXC_VECTOR(64'hD8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0] rom [0:127];
  assign bus.imem_q_i = rom[bus.imem_addr_o];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model of the architectural state visible at the stage outputs.
  logic [63:0] m_pc, m_ipc;
  logic        m_valid, m_fault;
  logic [31:0] m_instr;

  task automatic idle();
    bus.stall_i = 0; bus.branch_taken_i = 0; bus.branch_target_i = '0;
    bus.exc_i = 0; bus.eret_i = 0; bus.elr_i = '0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic cycle();
    logic        f;
    logic [63:0] npc;
    f = (m_pc % 4 != 0) || (m_pc >= 64'd512);
    if (reset) begin
      npc = 0; m_valid = 0; m_ipc = 0; m_instr = 0; m_fault = 0;
    end else begin
      if (bus.exc_i)               npc = 64'hD8;
      else if (bus.eret_i)         npc = bus.elr_i;
      else if (bus.branch_taken_i) npc = bus.branch_target_i;
      else if (bus.stall_i)        npc = m_pc;
      else                         npc = m_pc + 64'd4;
      if (bus.exc_i || bus.eret_i || bus.branch_taken_i) begin
        m_valid = 0; m_ipc = 0; m_instr = 0; m_fault = 0;
      end else if (!bus.stall_i) begin
        m_valid = 1; m_ipc = m_pc; m_fault = f;
        m_instr = f ? 32'h0 : rom[m_pc / 4];
      end
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    bus.exc_i = 1; bus.branch_taken_i = 1; bus.branch_target_i = 64'h40;
    cycle();
    cycle();
    idle();
    reset = 0;
    vectors++;
    if (bus.pc_o !== 64'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
    vectors++;
    if (bus.ifid_valid_o !== 1'b0 || bus.ifid_pc_o !== 64'h0 || bus.ifid_instr_o !== 32'h0 || bus.ifid_fault_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ifid: got v=%b pc=%h i=%h f=%b want all zero",
               bus.ifid_valid_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_fault_o);
    end
    $display("reset: pc=%h ifid_valid=%b", bus.pc_o, bus.ifid_valid_o);
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [3];
    logic [31:0] exp_i  [3];
    exp_pc = '{64'h0, 64'h4, 64'h8};
    exp_i  = '{32'h8b050083, 32'hf8018003, 32'hcb050083};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.imem_addr_o !== 7'(k)) begin miscompares++; $display("FAIL seq_addr%0d: got %0d want %0d", k, bus.imem_addr_o, k); end
      cycle();
      vectors++;
      if (bus.ifid_valid_o !== 1'b1 || bus.ifid_pc_o !== exp_pc[k] || bus.ifid_instr_o !== exp_i[k]) begin
        miscompares++;
        $display("FAIL seq_ifid%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 k, bus.ifid_valid_o, bus.ifid_pc_o, bus.ifid_instr_o, exp_pc[k], exp_i[k]);
      end
      $display("seq %0d: ifid pc=%h instr=%h", k, bus.ifid_pc_o, bus.ifid_instr_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(); cycle();
    bus.stall_i = 1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      vectors++;
      if (bus.pc_o !== 64'h8 || bus.ifid_pc_o !== 64'h4 || bus.ifid_instr_o !== 32'hf8018003 || bus.ifid_valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got pc=%h ifid=%h/%h want pc=8 ifid=4/f8018003",
                 k, bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o);
      end
    end
    bus.stall_i = 0;
    cycle();
    vectors++;
    if (bus.pc_o !== 64'hC || bus.ifid_pc_o !== 64'h8 || bus.ifid_instr_o !== 32'hcb050083) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h ifid=%h/%h want pc=c ifid=8/cb050083",
               bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o);
    end
    $display("stall release: pc=%h ifid pc=%h", bus.pc_o, bus.ifid_pc_o);
  endtask

  task automatic test_branch_stall();
    bus.branch_taken_i = 1; bus.branch_target_i = 64'h80; bus.stall_i = 1;
    cycle();
    idle();
    vectors++;
    if (bus.pc_o !== 64'h80 || bus.ifid_valid_o !== 1'b0 || bus.ifid_instr_o !== 32'h0 || bus.ifid_pc_o !== 64'h0) begin
      miscompares++;
      $display("FAIL branch_flush: got pc=%h v=%b i=%h ipc=%h want pc=80 v=0 i=0 ipc=0",
               bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o);
    end
    cycle();
    vectors++;
    if (bus.ifid_valid_o !== 1'b1 || bus.ifid_pc_o !== 64'h80 || bus.ifid_instr_o !== 32'h8b1f03ed) begin
      miscompares++;
      $display("FAIL branch_fetch: got v=%b pc=%h i=%h want v=1 pc=80 i=8b1f03ed",
               bus.ifid_valid_o, bus.ifid_pc_o, bus.ifid_instr_o);
    end
    $display("branch: ifid pc=%h instr=%h", bus.ifid_pc_o, bus.ifid_instr_o);
  endtask

  task automatic test_priority();
    bus.exc_i = 1; bus.eret_i = 1; bus.elr_i = 64'h44;
    bus.branch_taken_i = 1; bus.branch_target_i = 64'h10;
    cycle();
    idle();
    vectors++;
    if (bus.pc_o !== 64'hD8 || bus.imem_addr_o !== 7'd54) begin
      miscompares++;
      $display("FAIL exc_priority: got pc=%h addr=%0d want pc=d8 addr=54", bus.pc_o, bus.imem_addr_o);
    end
    cycle();
    vectors++;
    if (bus.ifid_instr_o !== 32'hd5382014 || bus.ifid_pc_o !== 64'hD8) begin
      miscompares++;
      $display("FAIL exc_fetch: got i=%h pc=%h want i=d5382014 pc=d8", bus.ifid_instr_o, bus.ifid_pc_o);
    end
    $display("exception: ifid instr=%h", bus.ifid_instr_o);
  endtask

  task automatic test_eret();
    bus.eret_i = 1; bus.elr_i = 64'h44;
    cycle();
    idle();
    vectors++;
    if (bus.imem_addr_o !== 7'd17) begin miscompares++; $display("FAIL eret_addr: got %0d want 17", bus.imem_addr_o); end
    cycle();
    vectors++;
    if (bus.ifid_instr_o !== 32'hffffffff || bus.ifid_fault_o !== 1'b0) begin
      miscompares++;
      $display("FAIL eret_fetch: got i=%h f=%b want i=ffffffff f=0", bus.ifid_instr_o, bus.ifid_fault_o);
    end
    $display("eret: ifid instr=%h", bus.ifid_instr_o);
  endtask

  task automatic test_fault();
    bus.branch_taken_i = 1; bus.branch_target_i = 64'h202;
    cycle(); idle(); cycle();
    vectors++;
    if (bus.ifid_valid_o !== 1'b1 || bus.ifid_fault_o !== 1'b1 || bus.ifid_instr_o !== 32'h0 || bus.pc_o !== 64'h206) begin
      miscompares++;
      $display("FAIL fault_misaligned: got v=%b f=%b i=%h pc=%h want v=1 f=1 i=0 pc=206",
               bus.ifid_valid_o, bus.ifid_fault_o, bus.ifid_instr_o, bus.pc_o);
    end
    bus.branch_taken_i = 1; bus.branch_target_i = 64'h200;
    cycle(); idle(); cycle();
    vectors++;
    if (bus.ifid_fault_o !== 1'b1 || bus.ifid_pc_o !== 64'h200 || bus.ifid_instr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL fault_range: got f=%b pc=%h i=%h want f=1 pc=200 i=0",
               bus.ifid_fault_o, bus.ifid_pc_o, bus.ifid_instr_o);
    end
    bus.branch_taken_i = 1; bus.branch_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle(); idle(); cycle();
    vectors++;
    if (bus.ifid_fault_o !== 1'b1 || bus.pc_o !== 64'h0) begin
      miscompares++;
      $display("FAIL fault_wrap: got f=%b pc=%h want f=1 pc=0", bus.ifid_fault_o, bus.pc_o);
    end
    cycle();
    vectors++;
    if (bus.ifid_pc_o !== 64'h0 || bus.ifid_instr_o !== 32'h8b050083 || bus.ifid_fault_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_fetch: got pc=%h i=%h f=%b want pc=0 i=8b050083 f=0",
               bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_fault_o);
    end
    $display("fault/wrap: ifid pc=%h fault=%b", bus.ifid_pc_o, bus.ifid_fault_o);
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 1023));
      2:       return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      default: return 64'($urandom_range(0, 127)) * 4;
    endcase
  endfunction

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      reset              = ($urandom_range(0, 63) == 0);
      bus.stall_i        = ($urandom_range(0, 3) == 0);
      bus.branch_taken_i = ($urandom_range(0, 7) == 0);
      bus.exc_i          = ($urandom_range(0, 19) == 0);
      bus.eret_i         = ($urandom_range(0, 11) == 0);
      bus.branch_target_i = rand_addr();
      bus.elr_i           = rand_addr();
      cycle();
      vectors++;
      if (bus.pc_o !== m_pc || bus.imem_addr_o !== 7'(m_pc >> 2) || bus.ifid_valid_o !== m_valid ||
          bus.ifid_pc_o !== m_ipc || bus.ifid_instr_o !== m_instr || bus.ifid_fault_o !== m_fault) begin
        miscompares++;
        bad++;
        $display("FAIL random%0d: got pc=%h v=%b ipc=%h i=%h f=%b want pc=%h v=%b ipc=%h i=%h f=%b",
                 k, bus.pc_o, bus.ifid_valid_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_fault_o,
                 m_pc, m_valid, m_ipc, m_instr, m_fault);
      end
    end
    reset = 0;
    idle();
    $display("random: 400 cycles, %0d differences", bad);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0]  = 32'h8b050083;
    rom[1]  = 32'hf8018003;
    rom[2]  = 32'hcb050083;
    rom[17] = 32'hffffffff;
    rom[32] = 32'h8b1f03ed;
    rom[54] = 32'hd5382014;
    m_pc = 0; m_ipc = 0; m_valid = 0; m_fault = 0; m_instr = 0;
    reset = 1;
    idle();
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_priority();
    test_eret();
    test_fault();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
